// File: rtl/gcm_board_ctrl.sv
// Board controller for gcm_aes: chunked switch entry of key/IV/PT, one GCM launch,
// paged display of {ciphertext, tag}. Define GCM_CTRL_AAD_EN to add a 128-bit AAD entry stage.
module gcm_board_ctrl #(
  parameter int SW_W    = 16,
  parameter int DISP_W  = 16,
  parameter int TIMEOUT = 4096,
  localparam int PAGES  = 256 / DISP_W,
  localparam int PW     = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic [SW_W-1:0]   i_sw,
  input  logic              i_load,
  input  logic              i_next,
  output logic [127:0]      o_cipher_key,
  output logic [95:0]       o_iv,
  output logic [127:0]      o_plain_text,
  output logic [127:0]      o_aad,
  output logic [63:0]       o_aad_size,
  output logic              o_new_instance,
  output logic              o_pt_instance,
  input  logic [127:0]      i_cipher_text,
  input  logic [127:0]      i_tag,
  input  logic              i_tag_ready,
  output logic [DISP_W-1:0] o_disp_data,
  output logic              o_disp_refresh,
  output logic [PW-1:0]     o_page,
  output logic [2:0]        o_state,
  output logic              o_error
);
  localparam int KEY_N = 128 / SW_W;
  localparam int IV_N  = 96 / SW_W;
  localparam int PT_N  = 128 / SW_W;
  localparam int CW    = $clog2(KEY_N + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [15:0] DEAD16 = 16'hDEAD;
`ifdef GCM_CTRL_AAD_EN
  localparam logic [63:0] AAD_SZ = 64'd128;
`else
  localparam logic [63:0] AAD_SZ = 64'd0;
`endif

  // 16'hDEAD repeated across the word, truncated for narrow displays
  function automatic logic [DISP_W-1:0] dead_word();
    logic [DISP_W-1:0] w;
    w = '0;
    for (int i = 0; i < DISP_W; i++) w[i] = DEAD16[i % 16];
    return w;
  endfunction
  localparam logic [DISP_W-1:0] DEAD = dead_word();

  typedef enum logic [2:0] {
    S_KEY = 3'd0, S_IV = 3'd1, S_PT = 3'd2, S_AAD = 3'd3,
    S_START = 3'd4, S_WAIT = 3'd5, S_SHOW = 3'd6, S_ERR = 3'd7
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     chunk, chunk_n;
  logic [TW-1:0]     tmo, tmo_n;
  logic [PW-1:0]     page, page_n;
  logic [127:0]      key, key_n, pt, pt_n, aad, aad_n;
  logic [95:0]       iv, iv_n;
  logic [255:0]      res, res_n;
  logic              err, err_n, start_n, refresh_n;
  logic [DISP_W-1:0] disp_n;
  int                base;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state          <= S_KEY;
      chunk          <= '0;
      tmo            <= '0;
      page           <= '0;
      key            <= '0;
      iv             <= '0;
      pt             <= '0;
      aad            <= '0;
      res            <= '0;
      err            <= 1'b0;
      o_new_instance <= 1'b0;
      o_disp_refresh <= 1'b0;
      o_disp_data    <= '0;
      o_aad_size     <= '0;
    end else begin
      state          <= state_n;
      chunk          <= chunk_n;
      tmo            <= tmo_n;
      page           <= page_n;
      key            <= key_n;
      iv             <= iv_n;
      pt             <= pt_n;
      aad            <= aad_n;
      res            <= res_n;
      err            <= err_n;
      o_new_instance <= start_n;
      o_disp_refresh <= refresh_n;
      o_disp_data    <= disp_n;
      o_aad_size     <= AAD_SZ;
    end
  end

  always_comb begin
    state_n   = state;
    chunk_n   = chunk;
    tmo_n     = tmo;
    page_n    = page;
    key_n     = key;
    iv_n      = iv;
    pt_n      = pt;
    aad_n     = aad;
    res_n     = res;
    err_n     = err;
    start_n   = 1'b0;
    refresh_n = 1'b0;
    case (state)
      S_KEY: if (i_load) begin
        key_n = {key[127-SW_W:0], i_sw};
        if (chunk == CW'(KEY_N - 1)) begin
          chunk_n = '0;
          state_n = S_IV;
        end else chunk_n = chunk + 1'b1;
      end
      S_IV: if (i_load) begin
        iv_n = {iv[95-SW_W:0], i_sw};
        if (chunk == CW'(IV_N - 1)) begin
          chunk_n = '0;
          state_n = S_PT;
        end else chunk_n = chunk + 1'b1;
      end
      S_PT: if (i_load) begin
        pt_n = {pt[127-SW_W:0], i_sw};
        if (chunk == CW'(PT_N - 1)) begin
          chunk_n = '0;
`ifdef GCM_CTRL_AAD_EN
          state_n = S_AAD;
`else
          state_n = S_START;
          start_n = 1'b1;
`endif
        end else chunk_n = chunk + 1'b1;
      end
`ifdef GCM_CTRL_AAD_EN
      S_AAD: if (i_load) begin
        aad_n = {aad[127-SW_W:0], i_sw};
        if (chunk == CW'(PT_N - 1)) begin
          chunk_n = '0;
          state_n = S_START;
          start_n = 1'b1;
        end else chunk_n = chunk + 1'b1;
      end
`endif
      S_START: begin
        state_n = S_WAIT;
        tmo_n   = '0;
      end
      S_WAIT: begin
        tmo_n = tmo + 1'b1;
        // tag on the final allowed cycle still wins over the timeout
        if (i_tag_ready) begin
          res_n     = {i_cipher_text, i_tag};
          page_n    = '0;
          state_n   = S_SHOW;
          refresh_n = 1'b1;
        end else if (tmo == TW'(TIMEOUT - 2)) begin
          state_n = S_ERR;
          err_n   = 1'b1;
        end
      end
      S_SHOW: begin
        if (i_load) state_n = S_KEY;
        else if (i_next) begin
          page_n    = (page == PW'(PAGES - 1)) ? '0 : page + 1'b1;
          refresh_n = 1'b1;
        end
      end
      S_ERR: if (i_load) begin
        err_n   = 1'b0;
        state_n = S_KEY;
      end
      default: state_n = S_KEY;
    endcase

    // page 0 is the top word of the result (ciphertext MSBs)
    base = (PAGES - 1 - int'(page_n)) * DISP_W;
    case (state_n)
      S_SHOW:  disp_n = res_n[base +: DISP_W];
      S_ERR:   disp_n = DEAD;
      default: disp_n = '0;
    endcase
  end

  assign o_cipher_key  = key;
  assign o_iv          = iv;
  assign o_plain_text  = pt;
  assign o_aad         = aad;
  assign o_pt_instance = o_new_instance;
  assign o_page        = page;
  assign o_state       = state;
  assign o_error       = err;
endmodule
